// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB device constants, widths and encodings
package usb_pkg;
    localparam int USB_DEPTH  = 64;
    localparam int USB_SIZE_W = 7;

    // Pointer width for a power-of-two byte depth; never narrower than one bit
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int USB_PTR_W = ptr_width(USB_DEPTH);

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        TX_PKT_NONE,
        TX_PKT_DATA0,
        TX_PKT_DATA1,
        TX_PKT_ACK,
        TX_PKT_NAK,
        TX_PKT_STALL
    } tx_packet_t;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - byte register file, synchronous write, asynchronous read
module fifo_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tx_data_buffer.sv
// rtl/tx_data_buffer.sv - transmit byte FIFO between the AHB-Lite slave and usb_tx
module tx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = USB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_tx_data,
    input  logic [7:0]            tx_data_in,
    input  logic                  get_tx_packet_data,
    output logic [7:0]            tx_packet_data,
    output logic [USB_SIZE_W-1:0] tx_packet_size,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [USB_SIZE_W-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  do_rd, do_wr, mem_we;
    logic [7:0]            mem_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == USB_SIZE_W'(DEPTH));
    assign empty = (count_q == '0);

    // A read frees a slot in the same edge, so a write while full still lands when paired with a read
    assign do_rd = get_tx_packet_data & ~empty;
    assign do_wr = store_tx_data & (~full | do_rd);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            mem_we = do_wr;
            if (do_wr) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + USB_SIZE_W'(do_wr) - USB_SIZE_W'(do_rd);
            if (store_tx_data & ~do_wr) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_fifo_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (tx_data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign tx_packet_data = empty ? 8'h00 : mem_rdata;
    assign tx_packet_size = count_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_tx_data_buffer.sv
// tb/tb_tx_data_buffer.sv - self-checking bench for tx_data_buffer
module tb_tx_data_buffer;
    localparam int D = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] tx_packet_size;
    logic       full, empty, overflow;

    int checks = 0;
    int failures = 0;

    byte unsigned q[$];
    bit           mov;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       g;
        logic       f;
        int         sz;
        logic [7:0] dat;
        logic       fu;
        logic       em;
        logic       ov;
    } vec_t;

    vec_t tbl[8];

    tx_data_buffer #(.DEPTH(D)) dut (
        .clk                (clk),
        .rst                (rst),
        .store_tx_data      (store_tx_data),
        .tx_data_in         (tx_data_in),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .tx_packet_size     (tx_packet_size),
        .flush              (flush),
        .full               (full),
        .empty              (empty),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a byte queue with the buffer's accept/drop rules
    function automatic void model_step(input bit s, input byte unsigned d, input bit g, input bit f);
        bit rd, wr;
        if (f) begin
            q.delete();
            mov = 1'b0;
        end else begin
            rd = g && (q.size() > 0);
            wr = s && ((q.size() < D) || rd);
            if (s && !wr) mov = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".size"}, int'(tx_packet_size), q.size());
        chk({tag, ".data"}, int'(tx_packet_data), (q.size() > 0) ? int'(q[0]) : 0);
        chk({tag, ".full"}, int'(full), int'(q.size() == D));
        chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
        chk({tag, ".ovf"}, int'(overflow), int'(mov));
    endtask

    task automatic step(input string tag, input bit s, input byte unsigned d, input bit g, input bit f);
        store_tx_data      = s;
        tx_data_in         = d;
        get_tx_packet_data = g;
        flush              = f;
        @(posedge clk);
        model_step(s, d, g, f);
        @(negedge clk);
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        flush              = 1'b0;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        mov = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_overflow();
        for (int i = 0; i < D; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full", int'(full), 1);
        chk("fill.size", int'(tx_packet_size), 64);
        step("ovf_wr", 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf.set", int'(overflow), 1);
        chk("ovf.size", int'(tx_packet_size), 64);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1, 8'hCC, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h33, 1'b0, 1'b0, 2, 8'hCC, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h82, 1'b1, 1'b0, 1, 8'h82, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h44, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};

        q.delete();
        mov = 1'b0;
        #12;
        chk("rst.size", int'(tx_packet_size), 0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full", int'(full), 0);
        chk("rst.data", int'(tx_packet_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Write accepted on the first edge after reset release
        step("first_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("first_wr.size", int'(tx_packet_size), 1);
        chk("first_wr.data", int'(tx_packet_data), 8'h5A);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            step("tbl", tbl[i].s, tbl[i].d, tbl[i].g, tbl[i].f);
            chk($sformatf("tbl%0d.size", i), int'(tx_packet_size), tbl[i].sz);
            chk($sformatf("tbl%0d.data", i), int'(tx_packet_data), int'(tbl[i].dat));
            chk($sformatf("tbl%0d.full", i), int'(full), int'(tbl[i].fu));
            chk($sformatf("tbl%0d.empty", i), int'(empty), int'(tbl[i].em));
            chk($sformatf("tbl%0d.ovf", i), int'(overflow), int'(tbl[i].ov));
        end

        // Full, overflow, in-order drain with the dropped FF never appearing
        do_reset();
        fill_overflow();
        for (int i = 0; i < D; i++) begin
            chk("drain.data", int'(tx_packet_data), i);
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain.empty", int'(empty), 1);
        chk("drain.ovf_sticky", int'(overflow), 1);

        // Read and write together while full
        do_reset();
        for (int i = 0; i < D; i++) step("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
        step("rw_full", 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("rw_full.size", int'(tx_packet_size), 64);
        chk("rw_full.ovf", int'(overflow), 0);
        chk("rw_full.head", int'(tx_packet_data), 1);
        for (int i = 0; i < D; i++) step("rw_full_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Read and write together at size 5
        step("flush5", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("w5", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("rw5", 1'b1, 8'h99, 1'b1, 1'b0);
        chk("rw5.size", int'(tx_packet_size), 5);
        chk("rw5.head", int'(tx_packet_data), 8'h11);

        // Pointer wrap: 48 in / 48 out, three rounds
        step("flushw", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 48; i++) step("wrap_w", 1'b1, 8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 48; i++) step("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap.size", int'(tx_packet_size), 0);

        // Flush with overflow set and a concurrent write
        do_reset();
        fill_overflow();
        for (int i = 0; i < 54; i++) step("to10", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_flush.size", int'(tx_packet_size), 10);
        chk("pre_flush.ovf", int'(overflow), 1);
        step("flush_wr", 1'b1, 8'h55, 1'b0, 1'b1);
        chk("flush.size", int'(tx_packet_size), 0);
        chk("flush.ovf", int'(overflow), 0);
        chk("flush.empty", int'(empty), 1);
        step("post_flush", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_flush.data", int'(tx_packet_data), 0);

        // Asynchronous reset mid-cycle while full with overflow
        do_reset();
        fill_overflow();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.size", int'(tx_packet_size), 0);
        chk("arst.data", int'(tx_packet_data), 0);
        chk("arst.empty", int'(empty), 1);
        chk("arst.full", int'(full), 0);
        chk("arst.ovf", int'(overflow), 0);
        q.delete();
        mov = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic in write-heavy, balanced and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int ws;
            ws = (((i / 300) % 3) == 0) ? 80 : ((((i / 300) % 3) == 1) ? 50 : 20);
            step("rand", ($urandom_range(99) < ws), 8'($urandom), ($urandom_range(99) < (100 - ws)),
                 ($urandom_range(199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning byte capacity; legal range is powers of two up to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port store_tx_data, input, 1 bit: write strobe from the AHB-Lite slave; one byte per high cycle.
REQ-005 SHALL have port tx_data_in, input, 8 bits: byte to store.
REQ-006 SHALL have port get_tx_packet_data, input, 1 bit: read strobe from usb_tx; one byte consumed per high cycle.
REQ-007 SHALL have port tx_packet_data, output, 8 bits: head byte, first-word fall-through.
REQ-008 SHALL have port tx_packet_size, output, 7 bits: current occupancy, 0..64.
REQ-009 SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-010 SHALL have ports full and empty, output, 1 bit each.
REQ-011 SHALL have port overflow, output, 1 bit: sticky error, set on write-when-full.

Function
REQ-012 SHALL store tx_data_in at the write pointer on a clock edge where store_tx_data=1 and the buffer is not full; write pointer increments mod DEPTH.
REQ-013 SHALL present the byte at the read pointer on tx_packet_data combinationally; with empty=1, tx_packet_data SHALL be 8'h00.
REQ-014 SHALL advance the read pointer mod DEPTH on a clock edge where get_tx_packet_data=1 and the buffer is not empty; the next byte is visible in the following cycle.
REQ-015 SHALL ignore get_tx_packet_data when empty: no pointer or count change.
REQ-016 SHALL drop a write when full, leave contents unchanged, and set overflow=1 at that edge.
REQ-017 SHALL hold overflow at 1 until flush or rst.
REQ-018 SHALL, on simultaneous read and write with 0 < count < DEPTH, perform both and leave count unchanged.
REQ-019 SHALL, on simultaneous read and write when empty, perform only the write (count 0->1).
REQ-020 SHALL, on simultaneous read and write when full, perform the read and the write: count stays DEPTH and overflow is not set.
REQ-021 SHALL, on flush=1, zero both pointers, count and overflow at that edge; flush has priority over simultaneous read and write, which are discarded.
REQ-022 SHALL derive full=(count==DEPTH) and empty=(count==0) from a registered 7-bit count; tx_packet_size equals count.
REQ-023 SHALL leave memory contents unaffected by flush and rst; only pointers are cleared.

Reset
REQ-024 SHALL, while rst=1, force pointers=0, count=0, overflow=0, empty=1, full=0, tx_packet_size=0 and tx_packet_data=8'h00, independent of clk.
REQ-025 SHALL accept a write on the first rising edge after rst deasserts.
REQ-026 SHALL discard all contents when rst asserts mid-transfer; usb_tx in progress then sees 8'h00 bytes.

Structure
REQ-027 SHALL take DEPTH, the pointer width and the 7-bit size width from the shared package usb_pkg, alongside the existing PID and tx_packet encodings.
REQ-028 SHALL place storage in one sub-module, fifo_mem: a DEPTH x 8 register file with a synchronous write port and an asynchronous read port. It SHALL contain no reset on the data array.
REQ-029 SHALL keep all pointer, count and flag logic in tx_data_buffer.

Verification
REQ-030 Reset: assert rst mid-cycle -> all outputs at reset values immediately, with no clock edge required.
REQ-031 Basic: write 8'hCC, 8'h33, then two read strobes -> tx_packet_data shows CC, then 33, then 00. tx_packet_size goes 1,2,1,0 and empty returns to 1.
REQ-032 Full and overflow: write 64 bytes 0..63 -> full=1, size=64. 65th write of 8'hFF -> overflow=1; reads return 0..63 in order and FF never appears.
REQ-033 Simultaneous: with size=5, pulse both strobes -> size stays 5 and head advances. With empty, pulse both with 8'h82 -> size=1 and head=82.
REQ-034 Wrap: repeat 48 writes then 48 reads three times -> data intact across pointer wrap, and size=0 at the end.
REQ-035 Flush: size=10 with overflow=1, assert flush together with a write -> size=0, overflow=0, empty=1, and the write is discarded.
